mem_bus_arbiter: RTL and testbench

Upstream front-end for the SPI external-memory controller. Accepts instruction-fetch and load/store requests from the RV32E core, arbitrates between them, and drives the controller's start/done handshake with byte count, address and write data. Extracts loaded values (sign/zero extension per RISC-V funct3) and returns them to the requester with a one-cycle valid pulse. Reports illegal access sizes and hung transactions as errors.

---
 rtl/mem_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates core fetch and load/store requests onto the SPI memory controller handshake.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifetch_req,
    input  logic [31:0] ifetch_addr,
    output logic [31:0] ifetch_data,
    output logic        ifetch_valid,
    input  logic        ls_req,
    input  logic        ls_is_write,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_valid,
    output logic        ls_error,
    output logic [2:0]  mem_num_bytes,
    output logic [31:0] mem_target_address,
    output logic        mem_is_write,
    output logic [31:0] mem_write_value,
    output logic        mem_start_request,
    input  logic [31:0] mem_fetched_data,
    input  logic        mem_request_done
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        owner_ls_q, owner_ls_d;
    logic [2:0]  f3_q, f3_d;
    logic [2:0]  nb_q, nb_d;
    logic [31:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [31:0] wval_q, wval_d;
    logic        start_q, start_d;
    logic [31:0] ifd_q, ifd_d;
    logic        ifv_q, ifv_d;
    logic [31:0] lsd_q, lsd_d;
    logic        lsv_q, lsv_d;
    logic        lse_q, lse_d;
    logic        ls_legal, grant, done_hit, to_hit, sx;
    logic [2:0]  req_nb;
    logic [31:0] wmask, res;
    assign ls_legal = (ls_funct3[1:0] != 2'b11) && !(ls_funct3[2] && (ls_is_write || ls_funct3[1]));
    assign req_nb   = ls_funct3[1:0] == 2'b00 ? 3'd1 : ls_funct3[1:0] == 2'b01 ? 3'd2 : 3'd4;
    assign wmask    = req_nb == 3'd1 ? {24'b0, ls_wdata[7:0]} : req_nb == 3'd2 ? {16'b0, ls_wdata[15:0]} : ls_wdata;
    assign grant    = state_q == IDLE && (ls_req || ifetch_req);
    assign done_hit = state_q == BUSY && mem_request_done;
    assign to_hit   = state_q == BUSY && !mem_request_done && cnt_q == 10'(TIMEOUT_CYCLES - 1);
    // Left-justified read data is shifted down; only signed LB/LH extend the top bit.
    assign sx  = !f3_q[2] && mem_fetched_data[31];
    assign res = nb_q == 3'd1 ? {{24{sx}}, mem_fetched_data[31:24]} :
                 nb_q == 3'd2 ? {{16{sx}}, mem_fetched_data[31:16]} : mem_fetched_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = (ls_req && !ls_legal) ? RELEASE : BUSY;
            BUSY:    if (done_hit || to_hit) state_d = RELEASE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        cnt_d      = state_q == BUSY ? cnt_q + 10'd1 : 10'd0;
        owner_ls_d = owner_ls_q;
        f3_d       = f3_q;
        nb_d       = nb_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wval_d     = wval_q;
        start_d    = start_q;
        ifd_d      = ifd_q;
        ifv_d      = 1'b0;
        lsd_d      = lsd_q;
        lsv_d      = 1'b0;
        lse_d      = 1'b0;
        if (grant && ls_req && !ls_legal) begin
            lsv_d = 1'b1;
            lse_d = 1'b1;
            lsd_d = 32'b0;
        end else if (grant) begin
            owner_ls_d = ls_req;
            f3_d       = ls_req ? ls_funct3 : 3'b010;
            nb_d       = ls_req ? req_nb : 3'd4;
            addr_d     = ls_req ? ls_addr : ifetch_addr;
            wr_d       = ls_req && ls_is_write;
            wval_d     = (ls_req && ls_is_write) ? wmask : 32'b0;
            start_d    = 1'b1;
        end
        if (done_hit || to_hit) begin
            start_d = 1'b0;
            if (owner_ls_q) begin
                lsv_d = 1'b1;
                lse_d = to_hit;
                lsd_d = (to_hit || wr_q) ? 32'b0 : res;
            end else begin
                ifv_d = 1'b1;
                ifd_d = to_hit ? 32'b0 : res;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            owner_ls_q <= 1'b0;
            f3_q       <= '0;
            nb_q       <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wval_q     <= '0;
            start_q    <= 1'b0;
            ifd_q      <= '0;
            ifv_q      <= 1'b0;
            lsd_q      <= '0;
            lsv_q      <= 1'b0;
            lse_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            owner_ls_q <= owner_ls_d;
            f3_q       <= f3_d;
            nb_q       <= nb_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wval_q     <= wval_d;
            start_q    <= start_d;
            ifd_q      <= ifd_d;
            ifv_q      <= ifv_d;
            lsd_q      <= lsd_d;
            lsv_q      <= lsv_d;
            lse_q      <= lse_d;
        end
    end
    assign ifetch_data        = ifd_q;
    assign ifetch_valid       = ifv_q;
    assign ls_rdata           = lsd_q;
    assign ls_valid           = lsv_q;
    assign ls_error           = lse_q;
    assign mem_num_bytes      = nb_q;
    assign mem_target_address = addr_q;
    assign mem_is_write       = wr_q;
    assign mem_write_value    = wval_q;
    assign mem_start_request  = start_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter with a simple memory-controller responder.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifetch_req = 1'b0;
    logic [31:0] ifetch_addr = '0;
    logic [31:0] ifetch_data;
    logic        ifetch_valid;
    logic        ls_req = 1'b0;
    logic        ls_is_write = 1'b0;
    logic [2:0]  ls_funct3 = '0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [31:0] ls_rdata;
    logic        ls_valid;
    logic        ls_error;
    logic [2:0]  mem_num_bytes;
    logic [31:0] mem_target_address;
    logic        mem_is_write;
    logic [31:0] mem_write_value;
    logic        mem_start_request;
    logic [31:0] mem_fetched_data = '0;
    logic        mem_request_done;
    logic        resp_en = 1'b1;
    int          vectors = 0;
    int          miscompares = 0;
    typedef struct {logic [31:0] d; logic e;} exp_t;
    exp_t ls_q[$];
    exp_t if_q[$];
    mem_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_data(ifetch_data), .ifetch_valid(ifetch_valid),
        .ls_req(ls_req), .ls_is_write(ls_is_write), .ls_funct3(ls_funct3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(ls_rdata), .ls_valid(ls_valid), .ls_error(ls_error),
        .mem_num_bytes(mem_num_bytes), .mem_target_address(mem_target_address), .mem_is_write(mem_is_write),
        .mem_write_value(mem_write_value), .mem_start_request(mem_start_request),
        .mem_fetched_data(mem_fetched_data), .mem_request_done(mem_request_done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    // Controller model: answers a held start request after three busy cycles.
    initial begin
        int lat;
        lat = 0;
        mem_request_done = 1'b0;
        forever begin
            @(negedge clk);
            mem_request_done = 1'b0;
            if (mem_start_request && resp_en) begin
                if (lat == 2) begin
                    mem_request_done = 1'b1;
                    lat = 0;
                end else lat++;
            end else lat = 0;
        end
    end
    // Scoreboard: each response pulse pops the expectation pushed when its request was driven.
    initial forever begin
        @(negedge clk);
        if (ls_valid) begin
            chk("ls_pending", 32'(ls_q.size() != 0), 32'd1);
            if (ls_q.size() != 0) begin
                exp_t e;
                e = ls_q.pop_front();
                chk("ls_rdata", ls_rdata, e.d);
                chk("ls_error", 32'(ls_error), 32'(e.e));
            end
            chk("ls_start_low", 32'(mem_start_request), 32'd0);
        end
        if (ifetch_valid) begin
            chk("if_pending", 32'(if_q.size() != 0), 32'd1);
            if (if_q.size() != 0) begin
                exp_t e;
                e = if_q.pop_front();
                chk("ifetch_data", ifetch_data, e.d);
            end
            chk("if_start_low", 32'(mem_start_request), 32'd0);
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic ls_txn(input logic [2:0] f3, input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] fd, input logic [31:0] er, input logic ee, output int busy, output int n);
        ls_q.push_back('{er, ee});
        mem_fetched_data = fd;
        ls_funct3 = f3;
        ls_is_write = we;
        ls_addr = a;
        ls_wdata = wd;
        ls_req = 1'b1;
        busy = 0;
        n = 0;
        @(negedge clk);
        while (!ls_valid && n < 3000) begin
            if (mem_start_request) busy++;
            n++;
            @(negedge clk);
        end
        chk("ls_valid_seen", 32'(ls_valid), 32'd1);
        ls_req = 1'b0;
        @(negedge clk);
        chk("ls_valid_pulse", 32'(ls_valid), 32'd0);
    endtask
    task automatic if_txn(input logic [31:0] a, input logic [31:0] fd, input logic [31:0] ed, output int busy);
        int n;
        if_q.push_back('{ed, 1'b0});
        mem_fetched_data = fd;
        ifetch_addr = a;
        ifetch_req = 1'b1;
        busy = 0;
        n = 0;
        @(negedge clk);
        while (!ifetch_valid && n < 3000) begin
            if (mem_start_request) busy++;
            n++;
            @(negedge clk);
        end
        chk("if_valid_seen", 32'(ifetch_valid), 32'd1);
        ifetch_req = 1'b0;
        @(negedge clk);
        chk("if_valid_pulse", 32'(ifetch_valid), 32'd0);
    endtask
    initial begin
        int busy, n, g;
        logic if_seen;
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(mem_start_request), 32'd0);
        chk("rst_ls_valid", 32'(ls_valid), 32'd0);
        chk("rst_if_valid", 32'(ifetch_valid), 32'd0);
        chk("rst_nb", 32'(mem_num_bytes), 32'd0);
        chk("rst_addr", mem_target_address, 32'd0);
        chk("rst_rdata", ls_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        ls_txn(3'b010, 1'b0, 32'h10, 32'h0, 32'h44332211, 32'h44332211, 1'b0, busy, n);
        chk("lw_nb", 32'(mem_num_bytes), 32'd4);
        chk("lw_wr", 32'(mem_is_write), 32'd0);
        chk("lw_addr", mem_target_address, 32'h10);
        chk("lw_busy", 32'(busy), 32'd3);
        ls_txn(3'b000, 1'b0, 32'h01000003, 32'h0, 32'h80000000, 32'hFFFFFF80, 1'b0, busy, n);
        chk("lb_nb", 32'(mem_num_bytes), 32'd1);
        ls_txn(3'b100, 1'b0, 32'h01000003, 32'h0, 32'h80000000, 32'h00000080, 1'b0, busy, n);
        ls_txn(3'b001, 1'b0, 32'h01000004, 32'h0, 32'hF2340000, 32'hFFFFF234, 1'b0, busy, n);
        chk("lh_nb", 32'(mem_num_bytes), 32'd2);
        ls_txn(3'b101, 1'b0, 32'h01000004, 32'h0, 32'hF2340000, 32'h0000F234, 1'b0, busy, n);
        ls_txn(3'b000, 1'b1, 32'h01000000, 32'hDEADBEAB, 32'h55555555, 32'h0, 1'b0, busy, n);
        chk("sb_nb", 32'(mem_num_bytes), 32'd1);
        chk("sb_wr", 32'(mem_is_write), 32'd1);
        chk("sb_wval", mem_write_value, 32'h000000AB);
        ls_txn(3'b001, 1'b1, 32'h01000008, 32'hDEADBEAB, 32'h55555555, 32'h0, 1'b0, busy, n);
        chk("sh_wval", mem_write_value, 32'h0000BEAB);
        // Simultaneous requests: store goes first, fetch follows after a start-low gap.
        ls_q.push_back('{32'h0, 1'b0});
        if_q.push_back('{32'hA5A5_0F0F, 1'b0});
        mem_fetched_data = 32'h12121212;
        ls_funct3 = 3'b010; ls_is_write = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h12345678;
        ifetch_addr = 32'h400;
        ls_req = 1'b1;
        ifetch_req = 1'b1;
        n = 0;
        if_seen = 1'b0;
        @(negedge clk);
        chk("arb_first_wr", 32'(mem_is_write), 32'd1);
        chk("arb_first_addr", mem_target_address, 32'h20);
        while (!ls_valid && n < 100) begin
            if_seen |= ifetch_valid;
            n++;
            @(negedge clk);
        end
        chk("arb_ls_valid", 32'(ls_valid), 32'd1);
        chk("arb_if_not_first", 32'(if_seen | ifetch_valid), 32'd0);
        chk("arb_sw_wval", mem_write_value, 32'h12345678);
        ls_req = 1'b0;
        mem_fetched_data = 32'hA5A5_0F0F;
        g = 0;
        while (!mem_start_request && g < 10) begin
            g++;
            @(negedge clk);
        end
        chk("arb_gap", 32'(g), 32'd2);
        chk("arb_if_addr", mem_target_address, 32'h400);
        chk("arb_if_nb", 32'(mem_num_bytes), 32'd4);
        chk("arb_if_wr", 32'(mem_is_write), 32'd0);
        n = 0;
        while (!ifetch_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("arb_if_valid", 32'(ifetch_valid), 32'd1);
        ifetch_req = 1'b0;
        @(negedge clk);
        // Illegal sizes answer next cycle without touching memory.
        ls_txn(3'b011, 1'b0, 32'h30, 32'h0, 32'h0, 32'h0, 1'b1, busy, n);
        chk("ill_latency", 32'(n), 32'd0);
        chk("ill_no_start", 32'(busy), 32'd0);
        chk("ill_addr_kept", mem_target_address, 32'h400);
        ls_txn(3'b100, 1'b1, 32'h34, 32'h0, 32'h0, 32'h0, 1'b1, busy, n);
        chk("ill_sbu_no_start", 32'(busy), 32'd0);
        ls_txn(3'b110, 1'b0, 32'h38, 32'h0, 32'h0, 32'h0, 1'b1, busy, n);
        chk("ill_l110_no_start", 32'(busy), 32'd0);
        // Timeouts with the responder silenced.
        resp_en = 1'b0;
        ls_txn(3'b010, 1'b0, 32'h40, 32'h0, 32'h99999999, 32'h0, 1'b1, busy, n);
        chk("to_ls_busy", 32'(busy), 32'd1023);
        if_txn(32'h500, 32'h99999999, 32'h0, busy);
        chk("to_if_busy", 32'(busy), 32'd1023);
        resp_en = 1'b1;
        if_txn(32'h504, 32'h00000013, 32'h00000013, busy);
        chk("if_busy", 32'(busy), 32'd3);
        // Asynchronous reset in the middle of a busy fetch; the held request restarts it.
        resp_en = 1'b0;
        if_q.push_back('{32'hCAFE0001, 1'b0});
        mem_fetched_data = 32'hCAFE0001;
        ifetch_addr = 32'h300;
        ifetch_req = 1'b1;
        n = 0;
        while (!mem_start_request && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("rb_started", 32'(mem_start_request), 32'd1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_start", 32'(mem_start_request), 32'd0);
        chk("rb_if_valid", 32'(ifetch_valid), 32'd0);
        chk("rb_ifetch_data", ifetch_data, 32'd0);
        chk("rb_nb", 32'(mem_num_bytes), 32'd0);
        chk("rb_addr", mem_target_address, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        resp_en = 1'b1;
        @(negedge clk);
        chk("rb_restart", 32'(mem_start_request), 32'd1);
        chk("rb_nb4", 32'(mem_num_bytes), 32'd4);
        chk("rb_addr2", mem_target_address, 32'h300);
        n = 0;
        while (!ifetch_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("rb_if_valid2", 32'(ifetch_valid), 32'd1);
        ifetch_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("ls_q_empty", 32'(ls_q.size()), 32'd0);
        chk("if_q_empty", 32'(if_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
